// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU memory bus. Provides a RAM_DEPTH x
//   DATA_W synchronous RAM, a memory-mapped LED register and a synchronized
//   switch input register. After reset an optional clear engine zeroes the
//   RAM. Unmapped or illegal accesses set a sticky error flag and capture
//   the address of the first offending access.
//
//   State table:
//     state    | meaning
//     ---------+-------------------------------------------------------
//     ST_CLEAR | zeroing RAM one word per cycle, bus commands ignored
//     ST_READY | clear done, bus commands serviced, mem_ready = 1
//
// Ports:
//   clk        in   system clock, all state updates on posedge
//   reset      in   asynchronous active-low reset (0 = in reset)
//   mem_cmd    in   2   00 none, 01 MREAD, 10 MWRITE, 11 illegal
//   mem_addr   in   ADDR_W  word address
//   write_data in   DATA_W  store data, sampled with MWRITE
//   read_data  out  DATA_W  registered read data (1-cycle latency)
//   sw         in   8   asynchronous board switches
//   led        out  8   LED register
//   mem_ready  out  1   high once the clear engine has finished
//   bus_err    out  1   sticky error flag
//   err_addr   out  ADDR_W  address of the first erroneous access
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 9,
    parameter int                RAM_DEPTH      = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR       = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR        = 9'h140,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic [7:0]        sw,
    output logic [7:0]        led,
    output logic              mem_ready,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int                CNT_W    = $clog2(RAM_DEPTH);
    localparam logic [CNT_W-1:0]  RAM_LAST = CNT_W'(RAM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(RAM_DEPTH);

    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              clearing;
    logic [CNT_W-1:0]  clr_cnt;

    logic [DATA_W-1:0] ram [RAM_DEPTH];

    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;

    logic              addr_is_ram;
    logic              addr_is_led;
    logic              addr_is_sw;
    logic [CNT_W-1:0]  ram_idx;
    logic              rd_req;
    logic              wr_req;
    logic              ill_req;
    logic              err_hit;

    // ------------------------------------------------------------------
    // Address decode; the full address is compared, so nothing aliases.
    // ------------------------------------------------------------------
    always_comb begin
        addr_is_ram = (mem_addr < RAM_TOP);
        addr_is_led = (mem_addr == LED_ADDR);
        addr_is_sw  = (mem_addr == SW_ADDR);
        ram_idx     = mem_addr[CNT_W-1:0];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clearing   = 1'b0;
        mem_ready  = 1'b0;
        case (state)
            ST_CLEAR: begin
                clearing = 1'b1;
                if (clr_cnt == RAM_LAST) begin
                    next_state = ST_READY;
                end
            end
            ST_READY: begin
                mem_ready = 1'b1;
            end
            default: begin
                next_state = ST_READY;
            end
        endcase
    end

    // Bus commands only take effect once the RAM has been cleared.
    always_comb begin
        rd_req  = mem_ready && (mem_cmd == CMD_READ);
        wr_req  = mem_ready && (mem_cmd == CMD_WRITE);
        ill_req = mem_ready && (mem_cmd == CMD_ILLEGAL);
        err_hit = ill_req
                | (rd_req && !(addr_is_ram || addr_is_led || addr_is_sw))
                | (wr_req && !(addr_is_ram || addr_is_led));
    end

    // ------------------------------------------------------------------
    // Clear counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (clearing) begin
            clr_cnt <= clr_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // RAM array: no reset so it can map onto block RAM; the clear engine
    // and bus writes never overlap because bus writes require ST_READY.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clearing) begin
            ram[clr_cnt] <= '0;
        end else if (wr_req && addr_is_ram) begin
            ram[ram_idx] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Switch synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Read data register: holds unless a valid MREAD is sampled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
        end else if (rd_req) begin
            if (addr_is_ram) begin
                read_data <= ram[ram_idx];
            end else if (addr_is_led) begin
                read_data <= DATA_W'(led);
            end else if (addr_is_sw) begin
                read_data <= DATA_W'(sw_sync);
            end else begin
                read_data <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else if (wr_req && addr_is_led) begin
            led <= write_data[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Sticky error capture: only the first error records its address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if (err_hit && !bus_err) begin
            bus_err  <= 1'b1;
            err_addr <= mem_addr;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_ILL   = 2'b11;
    localparam logic [8:0] LED_A   = 9'h100;
    localparam logic [8:0] SW_A    = 9'h140;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        mem_ready;
    logic        bus_err;
    logic [8:0]  err_addr;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    int n;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .sw         (sw),
        .led        (led),
        .mem_ready  (mem_ready),
        .bus_err    (bus_err),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_cmd    = C_NONE;
        mem_addr   = '0;
        write_data = '0;
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        cycle();
        idle();
    endtask

    task automatic do_read(input string tag, input logic [8:0] a, input logic [15:0] e);
        logic [15:0] want;
        exp_q.push_back(e);
        do_cmd(C_READ, a, 16'h0000);
        want = exp_q.pop_front();
        check(tag, read_data, want);
    endtask

    // Counts posedges from reset release until mem_ready; optionally pokes
    // the bus mid-clear with commands that must all be ignored.
    task automatic wait_ready(input bit poke, output int cnt);
        cnt = 0;
        while (!mem_ready && cnt < 400) begin
            if (poke && cnt == 100) begin
                mem_cmd = C_WRITE; mem_addr = 9'h010; write_data = 16'hDEAD;
            end else if (poke && cnt == 101) begin
                mem_cmd = C_READ; mem_addr = 9'h1F0; write_data = 16'h0000;
            end else if (poke && cnt == 102) begin
                mem_cmd = C_ILL; mem_addr = 9'h055; write_data = 16'h0000;
            end else begin
                idle();
            end
            cycle();
            cnt++;
        end
        idle();
    endtask

    initial begin
        reset = 1'b0;
        sw    = 8'h00;
        idle();
        repeat (3) cycle();

        check("rst_read_data", read_data, 16'h0000);
        check("rst_led", led, 8'h00);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_err_addr", err_addr, 9'h000);
        check("rst_mem_ready", mem_ready, 1'b0);

        // Test 1 + 5: clear latency with ignored bus traffic during CLEAR
        reset = 1'b1;
        wait_ready(1'b1, n);
        check("clear_latency", n, 256);
        check("clear_no_err", bus_err, 1'b0);
        check("clear_rd_hold", read_data, 16'h0000);
        do_read("rd_000", 9'h000, 16'h0000);
        do_read("rd_07f", 9'h07F, 16'h0000);
        do_read("rd_0ff", 9'h0FF, 16'h0000);
        do_read("rd_010_ignored_wr", 9'h010, 16'h0000);

        // Test 2: write then read same address, then hold
        do_cmd(C_WRITE, 9'h005, 16'hBEEF);
        check("wr_keeps_rd", read_data, 16'h0000);
        do_read("rd_005", 9'h005, 16'hBEEF);
        repeat (3) cycle();
        check("rd_hold", read_data, 16'hBEEF);

        do_cmd(C_WRITE, 9'h0FF, 16'h1234);
        do_read("rd_0ff_last", 9'h0FF, 16'h1234);
        do_read("rd_005_again", 9'h005, 16'hBEEF);

        // Test 3: LED register and switch synchronizer lag
        do_cmd(C_WRITE, LED_A, 16'h12A5);
        check("led_a5", led, 8'hA5);
        do_read("rd_led", LED_A, 16'h00A5);
        sw = 8'h3C;
        repeat (2) cycle();
        do_read("rd_sw_3c", SW_A, 16'h003C);
        sw = 8'h5A;
        do_read("sw_lag1", SW_A, 16'h003C);
        do_read("sw_lag2", SW_A, 16'h003C);
        do_read("sw_new", SW_A, 16'h005A);
        check("no_err_yet", bus_err, 1'b0);

        // Test 4: errors
        do_read("rd_unmapped", 9'h1F0, 16'h0000);
        check("err_flag", bus_err, 1'b1);
        check("err_addr_1f0", err_addr, 9'h1F0);
        do_cmd(C_WRITE, SW_A, 16'hFFFF);
        check("err_addr_sticky", err_addr, 9'h1F0);
        check("wr_sw_keeps_rd", read_data, 16'h0000);
        do_cmd(C_WRITE, 9'h101, 16'h7777);
        do_read("rd_101", 9'h101, 16'h0000);
        do_cmd(C_ILL, 9'h005, 16'h0000);
        do_cmd(C_ILL, LED_A, 16'h00FF);
        check("ill_led", led, 8'hA5);
        do_read("ill_ram", 9'h005, 16'hBEEF);
        check("err_addr_final", err_addr, 9'h1F0);

        // Test 6: reset from READY, then reset mid-clear
        reset = 1'b0;
        #2;
        check("rst2_led", led, 8'h00);
        check("rst2_read_data", read_data, 16'h0000);
        check("rst2_bus_err", bus_err, 1'b0);
        check("rst2_err_addr", err_addr, 9'h000);
        check("rst2_mem_ready", mem_ready, 1'b0);
        repeat (2) cycle();
        reset = 1'b1;
        repeat (100) cycle();
        check("mid_clear_not_ready", mem_ready, 1'b0);
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        wait_ready(1'b0, n);
        check("reclear_latency", n, 256);
        do_read("reclear_005", 9'h005, 16'h0000);
        do_read("reclear_0ff", 9'h0FF, 16'h0000);
        do_read("resync_sw", SW_A, 16'h005A);

        // Illegal command as the first error after reset
        do_cmd(C_ILL, 9'h033, 16'h0000);
        check("ill_err_flag", bus_err, 1'b1);
        check("ill_err_addr", err_addr, 9'h033);

        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
